// File: rtl/dualportram_pkg.sv
// Shared constants and types for the extended dual-port RAM and its read pipeline.
package dualportram_pkg;

    localparam int WRITE_MODE_READ_FIRST  = 0;
    localparam int WRITE_MODE_WRITE_FIRST = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/dualportram_rdpipe.sv
// Per-port read output pipeline: stage 1 captures on an accepted read, stage 2 follows
// stage 1 one cycle later when that read was accepted; READ_LATENCY picks the tap.
module dualportram_rdpipe #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic             r_en_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; stage 2 therefore sees last cycle's stage 1, not this cycle's.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
            r_en_d   <= 1'b0;
        end else begin
            r_en_d <= i_en;
            if (i_en)
                r_stage1 <= i_data;
            if (r_en_d)
                r_stage2 <= r_stage1;
        end
    end

    assign o_data = (READ_LATENCY == 2) ? r_stage2 : r_stage1;

endmodule

// File: rtl/dualportram_ex.sv
// True dual-port RAM with byte enables, read-during-write mode, out-of-range protection,
// write-collision flag and a post-reset clear sequencer.
module dualportram_ex
    import dualportram_pkg::*;
#(
    parameter int DEPTH          = 10,
    parameter int WIDTH          = 32,
    parameter int WORDS          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = WRITE_MODE_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BYTES         = bytes_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             we_b,
    input  logic [BYTES-1:0] be,
    input  logic [BYTES-1:0] be_b,
    input  logic             oe,
    input  logic             oe_b,
    input  logic [31:0]      address,
    input  logic [31:0]      address_b,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] din_b,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_b,
    output logic             busy,
    output logic             collision,
    output logic [31:0]      length
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [WIDTH-1:0] r_mem [WORDS];
    clr_state_t       r_state;
    clr_state_t       w_state_next;
    logic [AW-1:0]    r_clr_cnt;
    logic             r_collision;

    logic             w_busy;
    logic             w_in_a, w_in_b;
    logic             w_wr_a, w_wr_b;
    logic [AW-1:0]    w_idx_a, w_idx_b;
    logic [WIDTH-1:0] w_old_a, w_old_b;
    logic [WIDTH-1:0] w_merged_a, w_merged_b;
    logic [WIDTH-1:0] w_rd_a, w_rd_b;
    logic             w_unused_addr;

    assign w_busy = (r_state == ST_CLEAR);

    // Only address[DEPTH-1:0] is decoded; anything at or above WORDS is rejected.
    assign w_in_a  = {1'b0, address[DEPTH-1:0]}   < (DEPTH+1)'(WORDS);
    assign w_in_b  = {1'b0, address_b[DEPTH-1:0]} < (DEPTH+1)'(WORDS);
    assign w_idx_a = address[AW-1:0];
    assign w_idx_b = address_b[AW-1:0];
    assign w_unused_addr = ^{address[31:DEPTH], address_b[31:DEPTH]};

    assign w_wr_a = we   && !w_busy && w_in_a && (be   != '0);
    assign w_wr_b = we_b && !w_busy && w_in_b && (be_b != '0);

    assign w_old_a = r_mem[w_idx_a];
    assign w_old_b = r_mem[w_idx_b];

    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_merged_a = w_old_a;
        w_merged_b = w_old_b;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i])   w_merged_a[8*i +: 8] = din[8*i +: 8];
            if (be_b[i]) w_merged_b[8*i +: 8] = din_b[8*i +: 8];
        end
    end

    // Cross-port reads always see the pre-write word; same-port depends on WRITE_MODE.
    assign w_rd_a = !w_in_a ? '0 :
                    (WRITE_MODE == WRITE_MODE_WRITE_FIRST && w_wr_a) ? w_merged_a : w_old_a;
    assign w_rd_b = !w_in_b ? '0 :
                    (WRITE_MODE == WRITE_MODE_WRITE_FIRST && w_wr_b) ? w_merged_b : w_old_b;

    // NOTE: the array has no reset branch so it still maps to block RAM; zeroing is done
    // one word per cycle by the clear sequencer instead.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            if (!reset)
                r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                // Port A is written last so it wins on overlapping bytes.
                if (w_wr_b && be_b[i]) r_mem[w_idx_b][8*i +: 8] <= din_b[8*i +: 8];
                if (w_wr_a && be[i])   r_mem[w_idx_a][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) r_state <= ST_CLEAR;
            else                     r_state <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR)
                r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == AW'(WORDS - 1)) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_collision <= 1'b0;
        else
            r_collision <= w_wr_a && w_wr_b && (w_idx_a == w_idx_b) && ((be & be_b) != '0);
    end

    dualportram_rdpipe #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_rdpipe_a (
        .clk    (clk),
        .reset  (reset),
        .i_en   (oe && !w_busy),
        .i_data (w_rd_a),
        .o_data (dout)
    );

    dualportram_rdpipe #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_rdpipe_b (
        .clk    (clk),
        .reset  (reset),
        .i_en   (oe_b && !w_busy),
        .i_data (w_rd_b),
        .o_data (dout_b)
    );

    assign busy      = w_busy;
    assign collision = r_collision;
    assign length    = 32'(WORDS);

endmodule

// File: tb/tb_dualportram_ex.sv
// Drives two RAM variants (read-first/latency 1 and write-first/latency 2) with the same
// stimulus and compares both against a behavioural array model every cycle.
module tb_dualportram_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, we_b, oe, oe_b;
    logic [3:0]  be, be_b;
    logic [31:0] address, address_b, din, din_b;

    logic [31:0] d0_dout, d0_dout_b, d1_dout, d1_dout_b, len0, len1;
    logic        busy0, busy1, col0, col1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dualportram_ex #(.DEPTH(10), .WIDTH(32), .WORDS(16), .READ_LATENCY(1),
                     .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_rl1_rf (
        .clk(clk), .reset(reset), .we(we), .we_b(we_b), .be(be), .be_b(be_b),
        .oe(oe), .oe_b(oe_b), .address(address), .address_b(address_b),
        .din(din), .din_b(din_b), .dout(d0_dout), .dout_b(d0_dout_b),
        .busy(busy0), .collision(col0), .length(len0)
    );

    dualportram_ex #(.DEPTH(10), .WIDTH(32), .WORDS(16), .READ_LATENCY(2),
                     .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_rl2_wf (
        .clk(clk), .reset(reset), .we(we), .we_b(we_b), .be(be), .be_b(be_b),
        .oe(oe), .oe_b(oe_b), .address(address), .address_b(address_b),
        .din(din), .din_b(din_b), .dout(d1_dout), .dout_b(d1_dout_b),
        .busy(busy1), .collision(col1), .length(len1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return a[9:0] < 10'd16;
    endfunction

    logic [31:0] mem_m [16];
    int          clear_left = 0;
    logic        started = 1'b0;
    logic        exp_col = 1'b0;
    logic [31:0] rf_q  [2];     // read-first, latency 1: value of last accepted read
    logic [31:0] wf_q1 [2];     // write-first: value of last accepted read
    logic [31:0] wf_q2 [2];     // write-first, latency 2: what the port shows
    logic        acc_prev [2];  // whether the previous cycle's read was accepted

    logic [31:0] m_addr [2];
    logic [31:0] m_din  [2];
    logic [3:0]  m_be   [2];
    logic        m_we   [2];
    logic        m_oe   [2];
    logic        m_wr   [2];
    logic        m_busy;

    always @(posedge clk) begin
        m_addr[0] = address;  m_addr[1] = address_b;
        m_din[0]  = din;      m_din[1]  = din_b;
        m_be[0]   = be;       m_be[1]   = be_b;
        m_we[0]   = we;       m_we[1]   = we_b;
        m_oe[0]   = oe;       m_oe[1]   = oe_b;
        m_busy    = (clear_left != 0);
        for (int p = 0; p < 2; p++)
            m_wr[p] = m_we[p] && !m_busy && in_range(m_addr[p]);

        if (reset) begin
            started = 1'b1;
            exp_col = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rf_q[p] = '0; wf_q1[p] = '0; wf_q2[p] = '0; acc_prev[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] w;
                if (acc_prev[p]) wf_q2[p] = wf_q1[p];
                acc_prev[p] = m_oe[p] && !m_busy;
                if (acc_prev[p]) begin
                    w = in_range(m_addr[p]) ? mem_m[m_addr[p][3:0]] : 32'h0;
                    rf_q[p]  = w;
                    wf_q1[p] = (in_range(m_addr[p]) && m_wr[p]) ? merge(w, m_din[p], m_be[p]) : w;
                end
            end
            exp_col = m_wr[0] && m_wr[1] && (m_addr[0][9:0] == m_addr[1][9:0]) &&
                      ((m_be[0] & m_be[1]) != 4'h0);
            if (m_busy) begin
                mem_m[16 - clear_left] = '0;
                clear_left--;
            end
        end

        if (!m_busy) begin
            if (m_wr[1]) mem_m[m_addr[1][3:0]] = merge(mem_m[m_addr[1][3:0]], m_din[1], m_be[1]);
            if (m_wr[0]) mem_m[m_addr[0][3:0]] = merge(mem_m[m_addr[0][3:0]], m_din[0], m_be[0]);
        end
        if (reset) clear_left = 16;
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy_rl1",      32'(busy0), 32'(clear_left != 0));
            check("busy_rl2",      32'(busy1), 32'(clear_left != 0));
            check("collision_rl1", 32'(col0),  32'(exp_col));
            check("collision_rl2", 32'(col1),  32'(exp_col));
            check("dout_rl1_rf",   d0_dout,    rf_q[0]);
            check("dout_b_rl1_rf", d0_dout_b,  rf_q[1]);
            check("dout_rl2_wf",   d1_dout,    wf_q2[0]);
            check("dout_b_rl2_wf", d1_dout_b,  wf_q2[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        we = 0; we_b = 0; oe = 0; oe_b = 0; be = '0; be_b = '0;
        address = '0; address_b = '0; din = '0; din_b = '0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy0) n++;
            else break;
        end
        check(name, 32'(n), 32'd16);
        step();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        count_busy("busy_len_first");
        check("length_rl1", len0, 32'd16);
        check("length_rl2", len1, 32'd16);

        // Fill every word with ones, then reset and let the sequencer clear it.
        for (int i = 0; i < 16; i++) begin
            we = 1; be = 4'hF; address = 32'(i); din = 32'hFFFF_FFFF;
            step();
        end
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        count_busy("busy_len_clear");
        for (int i = 0; i < 16; i++) begin
            oe = 1; address = 32'(i);
            step();
            step();
            check("cleared_rl1", d0_dout, 32'h0);
            check("cleared_rl2", d1_dout, 32'h0);
        end
        idle_inputs();

        // Byte-enable merge, read back on port B.
        we = 1; be = 4'hF; address = 3; din = 32'hAABB_CCDD;
        step();
        be = 4'b0010; din = 32'h1122_3344;
        step();
        idle_inputs();
        oe_b = 1; address_b = 3;
        step();
        step();
        check("byte_merge_rl1", d0_dout_b, 32'hAABB_33DD);
        check("byte_merge_rl2", d1_dout_b, 32'hAABB_33DD);
        idle_inputs();

        // Same-port read-during-write.
        we = 1; be = 4'hF; address = 5; din = 32'h1;
        step();
        din = 32'h2; oe = 1;
        step();
        idle_inputs();
        address = 5;
        check("rdw_read_first", d0_dout, 32'h1);
        step();
        check("rdw_write_first", d1_dout, 32'h2);
        check("rdw_rf_hold", d0_dout, 32'h1);

        // Overlapping writes to one address, then disjoint byte enables.
        we = 1; address = 7; din = 32'h0000_00AA; be = 4'b0001;
        we_b = 1; address_b = 7; din_b = 32'h0000_BB00; be_b = 4'b0011;
        step();
        idle_inputs();
        check("collision_pulse", 32'(col0), 32'h1);
        step();
        check("collision_gone", 32'(col0), 32'h0);
        oe = 1; address = 7;
        step();
        step();
        check("collide_word_rl1", d0_dout, 32'h0000_BBAA);
        check("collide_word_rl2", d1_dout, 32'h0000_BBAA);
        idle_inputs();
        we = 1; address = 7; din = 32'h0000_0011; be = 4'b0001;
        we_b = 1; address_b = 7; din_b = 32'h0000_2200; be_b = 4'b0010;
        step();
        idle_inputs();
        check("no_collision", 32'(col1), 32'h0);
        oe = 1; address = 7;
        step();
        step();
        check("disjoint_word", d0_dout, 32'h0000_2211);
        idle_inputs();

        // oe dropped on the second read: the latency-2 port keeps the first value.
        oe = 1; address = 3;
        step();
        oe = 0; address = 7;
        step();
        step();
        check("oe_hold_rl2", d1_dout, 32'hAABB_33DD);
        check("oe_hold_rl1", d0_dout, 32'hAABB_33DD);

        // Out-of-range write is dropped and its read returns zero; no aliasing onto word 4.
        we = 1; be = 4'hF; address = 20; din = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        oe = 1; address = 20;
        step();
        step();
        check("oob_read_rl1", d0_dout, 32'h0);
        check("oob_read_rl2", d1_dout, 32'h0);
        address = 4;
        step();
        step();
        check("oob_no_alias", d0_dout, 32'h0);
        idle_inputs();

        // Reset reasserted part-way through a clear restarts the full sequence.
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) step();
        reset = 1;
        step();
        reset = 0;
        count_busy("busy_len_restart");

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            we        = 1'($urandom_range(0, 1));
            we_b      = 1'($urandom_range(0, 1));
            oe        = 1'($urandom_range(0, 3) != 0);
            oe_b      = 1'($urandom_range(0, 3) != 0);
            be        = 4'($urandom);
            be_b      = 4'($urandom);
            din       = $urandom;
            din_b     = $urandom;
            address   = 32'($urandom_range(0, 19)) | (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
            address_b = ($urandom_range(0, 2) == 0) ? address : 32'($urandom_range(0, 19));
            step();
        end
        reset = 0;
        idle_inputs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
